// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin arbiter that serialises single-beat
// read/write requests onto the 16-byte DFF RAM port and returns read data with a
// one-cycle valid pulse to the requester that issued the read.
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_mar,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              ram_ce_n,
    output logic              ram_lr_n,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              cur_id;
    logic              cur_we;

    logic              pick1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Pick the winner among the pending requests; on a tie the requester that
    // did not win last time goes next, so contention alternates fairly.
    always_comb begin
        pick1     = 1'b0;
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (req1 && (!req0 || !last_grant)) begin
            pick1 = 1'b1;
        end
        if (pick1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // Sequencer: accept one request in IDLE, strobe the RAM for one cycle,
    // then either finish (write) or capture the registered read data (read).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            cur_we      <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            ram_mar     <= '0;
            ram_data_in <= '0;
            ram_ce_n    <= 1'b1;
            ram_lr_n    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            ram_ce_n <= 1'b1;
            ram_lr_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        last_grant  <= pick1;
                        cur_id      <= pick1;
                        cur_we      <= sel_we;
                        ram_mar     <= sel_addr;
                        ram_data_in <= sel_wdata;
                        if (sel_we) begin
                            ram_lr_n <= 1'b0;
                        end else begin
                            ram_ce_n <= 1'b0;
                        end
                        gnt0  <= !pick1;
                        gnt1  <= pick1;
                        busy  <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cur_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata   <= ram_data_out;
                    rvalid0 <= !cur_id;
                    rvalid1 <= cur_id;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural RAM,
// a transaction-level reference model and a per-cycle output comparison.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0 = 1'b0;
    logic              we0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [DATA_W-1:0] wdata0 = '0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1 = 1'b0;
    logic              we1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [DATA_W-1:0] wdata1 = '0;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_mar;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out = '0;
    logic              ram_ce_n;
    logic              ram_lr_n;
    logic              busy;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .ram_mar(ram_mar), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_ce_n(ram_ce_n), .ram_lr_n(ram_lr_n), .busy(busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // The RAM itself: writes on a low lr_n, registered read on a low ce_n.
    logic [DATA_W-1:0] ram_mem [0:15] = '{default: 8'h00};
    always @(posedge clk) begin
        if (!ram_lr_n) ram_mem[ram_mar] <= ram_data_in;
        if (!ram_ce_n) ram_data_out <= ram_mem[ram_mar];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Reference model: one transaction in flight, described by its grant cycle.
    logic [DATA_W-1:0] model_mem [0:15] = '{default: 8'h00};
    int                m_cyc = 0;
    int                m_g = 0;
    logic              m_txn = 1'b0;
    logic              m_we = 1'b0;
    logic              m_id = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wd = '0;
    logic              m_last = 1'b1;
    logic              m_win;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [ADDR_W-1:0] m_mar = '0;
    logic [DATA_W-1:0] m_din = '0;

    task automatic model_step();
        if (rst) begin
            m_txn   = 1'b0;
            m_last  = 1'b1;
            m_rdata = '0;
            m_mar   = '0;
            m_din   = '0;
        end else begin
            m_cyc++;
            if (m_txn && m_we && m_cyc == m_g + 1) model_mem[m_addr] = m_wd;
            if (m_txn && !m_we && m_cyc == m_g + 2) m_rdata = model_mem[m_addr];
            if ((!m_txn || m_cyc >= m_g + (m_we ? 2 : 3)) && (req0 || req1)) begin
                if (req0 && req1) m_win = (m_last == 1'b0);
                else              m_win = req1;
                m_last = m_win;
                m_id   = m_win;
                m_we   = m_win ? we1 : we0;
                m_addr = m_win ? addr1 : addr0;
                m_wd   = m_win ? wdata1 : wdata0;
                m_mar  = m_addr;
                m_din  = m_wd;
                m_g    = m_cyc;
                m_txn  = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle comparison of every DUT output against the model.
    initial forever begin
        logic strobe;
        @(negedge clk);
        strobe = m_txn && (m_cyc == m_g);
        check_output("gnt0", gnt0, strobe && !m_id);
        check_output("gnt1", gnt1, strobe && m_id);
        check_output("ram_lr_n", ram_lr_n, !(strobe && m_we));
        check_output("ram_ce_n", ram_ce_n, !(strobe && !m_we));
        check_output("rvalid0", rvalid0, m_txn && !m_we && m_cyc == m_g + 2 && !m_id);
        check_output("rvalid1", rvalid1, m_txn && !m_we && m_cyc == m_g + 2 && m_id);
        check_output("busy", busy, m_txn && (m_cyc == m_g || (!m_we && m_cyc == m_g + 1)));
        check_output("rdata", rdata, m_rdata);
        check_output("ram_mar", ram_mar, m_mar);
        check_output("ram_data_in", ram_data_in, m_din);
        check_output("strobe_excl", ram_ce_n | ram_lr_n, 1'b1);
    end

    // Record the order in which grants are issued.
    int grant_log [$];
    initial forever begin
        @(negedge clk);
        if (gnt0) grant_log.push_back(0);
        if (gnt1) grant_log.push_back(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Raise a request at a falling edge, hold it until its grant, then drop it.
    task automatic apply_stimulus(input int id, input logic we, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d, output int waits);
        logic got;
        if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        waits = 0;
        got   = 1'b0;
        while (!got && waits < 40) begin
            @(negedge clk);
            waits++;
            got = (id == 0) ? gnt0 : gnt1;
        end
        check_output("gnt_seen", got, 1'b1);
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic read_check(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expd);
        int   w;
        int   cnt;
        logic seen;
        apply_stimulus(id, 1'b0, a, 8'h00, w);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 10) begin
            @(negedge clk);
            cnt++;
            seen = (id == 0) ? rvalid0 : rvalid1;
        end
        check_output("rvalid_latency", cnt, 2);
        check_output("read_data", rdata, expd);
        check_output("other_rvalid", (id == 0) ? rvalid1 : rvalid0, 1'b0);
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int cnt;
        logic [DATA_W-1:0] v;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Write then read back, with literal timing.
        apply_stimulus(0, 1'b1, 4'h3, 8'hA5, w);
        check_output("t1_gnt_latency", w, 1);
        check_output("t1_lr_n", ram_lr_n, 1'b0);
        check_output("t1_mar", ram_mar, 4'h3);
        check_output("t1_din", ram_data_in, 8'hA5);
        @(negedge clk);
        check_output("t1_busy_cleared", busy, 1'b0);
        read_check(0, 4'h3, 8'hA5);

        // First tie after reset goes to requester 0.
        apply_stimulus(0, 1'b1, 4'h1, 8'h11, w);
        apply_stimulus(0, 1'b1, 4'h2, 8'h22, w);
        apply_reset();
        grant_log.delete();
        fork
            read_check(0, 4'h1, 8'h11);
            read_check(1, 4'h2, 8'h22);
        join
        check_output("tie_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_output("tie_first", grant_log[0], 0);
            check_output("tie_second", grant_log[1], 1);
        end

        // Sustained contention alternates grants.
        repeat (2) @(negedge clk);
        grant_log.delete();
        fork
            begin
                int wa;
                for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, 4'(i), 8'h00, wa);
            end
            begin
                int wb;
                for (int j = 0; j < 4; j++) apply_stimulus(1, 1'b0, 4'(j + 4), 8'h00, wb);
            end
        join
        repeat (4) @(negedge clk);
        check_output("contention_count", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size() && k < 8; k++)
            check_output("contention_order", grant_log[k], k % 2);

        // A request arriving while busy waits until the read completes.
        apply_stimulus(0, 1'b0, 4'h3, 8'h00, w);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2; wdata1 = 8'h00;
        cnt = 0;
        while (!gnt1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) begin
                check_output("busy_rvalid0", rvalid0, 1'b1);
                check_output("busy_rdata", rdata, 8'hA5);
            end
        end
        req1 = 1'b0;
        check_output("busy_gnt1_delay", cnt, 3);
        repeat (4) @(negedge clk);
        check_output("busy_rdata1", rdata, 8'h22);

        // Reset during the ACCESS cycle of a write drops it.
        apply_stimulus(0, 1'b1, 4'h7, 8'h5A, w);
        #1 rst = 1'b1;
        #1;
        check_output("rst_gnt0", gnt0, 1'b0);
        check_output("rst_lr_n", ram_lr_n, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_mar", ram_mar, 4'h0);
        check_output("rst_rdata", rdata, 8'h00);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        read_check(0, 4'h7, 8'h00);

        // Back-to-back writes by requester 1, one grant every two cycles.
        for (int a = 0; a < 16; a++) begin
            v = 8'(a) ^ 8'hFF;
            apply_stimulus(1, 1'b1, 4'(a), v, w);
            if (a > 0) check_output("b2b_spacing", w, 2);
        end
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            v = 8'(a) ^ 8'hFF;
            read_check(1, 4'(a), v);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
